// File: rtl/input_control.sv
// Board input conditioning for the door controller: sync, debounce,
// edge detect and request acceptance for the two keys and panic switch.
module input_control #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] key_n,
  input  logic       sw_panic,
  input  logic       busy,
  output logic       open_req,
  output logic       door_sel,
  output logic       panic_on,
  output logic       panic_rise,
  output logic       panic_fall,
  output logic [1:0] key_state,
  output logic [7:0] req_count
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       din;
  logic [2:0]       lvl;
  logic [2:0]       lvl_q;
  logic [CNT_W-1:0] cnt [3];
  logic [1:0]       press;
  logic             accept;
  logic             door_nxt;

  // bit2 = panic, bits1:0 = keys; flops hold the raw idle levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 3'b011;
      s2 <= 3'b011;
    end else begin
      s1 <= {sw_panic, key_n};
      s2 <= s1;
    end
  end

  assign din = {s2[2], ~s2[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl <= '0;
      for (int i = 0; i < 3; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (din[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          lvl[i] <= din[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press  = lvl[1:0] & ~lvl_q[1:0];
  assign accept = (|press) & ~busy & ~lvl[2];

  // key 0 wins a simultaneous press
  always_comb begin
    door_nxt = door_sel;
    priority case (1'b1)
      press[0]: door_nxt = 1'b0;
      press[1]: door_nxt = 1'b1;
      default:  door_nxt = door_sel;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q      <= '0;
      open_req   <= 1'b0;
      door_sel   <= 1'b0;
      req_count  <= '0;
      panic_rise <= 1'b0;
      panic_fall <= 1'b0;
    end else begin
      lvl_q      <= lvl;
      open_req   <= accept;
      panic_rise <= lvl[2] & ~lvl_q[2];
      panic_fall <= ~lvl[2] & lvl_q[2];
      if (accept) begin
        door_sel  <= door_nxt;
        req_count <= req_count + 8'd1;
      end
    end
  end

  assign key_state = lvl[1:0];
  assign panic_on  = lvl[2];

endmodule

// File: tb/tb_input_control.sv
// Scoreboard bench for input_control with DEBOUNCE_CYCLES=4.
// Stimulus pushes expected pulses; a negedge monitor pops and compares.
module tb_input_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_n;
  logic       sw_panic;
  logic       busy;
  logic       open_req;
  logic       door_sel;
  logic       panic_on;
  logic       panic_rise;
  logic       panic_fall;
  logic [1:0] key_state;
  logic [7:0] req_count;

  input_control #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .sw_panic(sw_panic),
    .busy(busy),
    .open_req(open_req),
    .door_sel(door_sel),
    .panic_on(panic_on),
    .panic_rise(panic_rise),
    .panic_fall(panic_fall),
    .key_state(key_state),
    .req_count(req_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       door;
    logic [7:0] cnt;
  } req_t;

  typedef struct {
    int   cyc;
    logic rise;
  } pan_t;

  req_t       rq[$];
  pan_t       pq[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] rc = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (open_req) begin
        if (rq.size() == 0) begin
          chk("unexpected_open_req", 1, 0);
        end else begin
          req_t e;
          e = rq.pop_front();
          chk("open_req_cycle", cyc, e.cyc);
          chk("door_sel", int'(door_sel), int'(e.door));
          chk("req_count", int'(req_count), int'(e.cnt));
        end
      end
      if (panic_rise || panic_fall) begin
        if (pq.size() == 0) begin
          chk("unexpected_panic_pulse", 1, 0);
        end else begin
          pan_t p;
          p = pq.pop_front();
          chk("panic_cycle", cyc, p.cyc);
          chk("panic_rise", int'(panic_rise), int'(p.rise));
          chk("panic_fall", int'(panic_fall), int'(!p.rise));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_press(input logic [1:0] kn, input logic b,
                          input bit ok, input logic d);
    key_n = kn;
    busy  = b;
    if (ok) begin
      rc = rc + 8'd1;
      rq.push_back('{cyc + 7, d, rc});
    end
    step(10);
    key_n = 2'b11;
    step(10);
    busy = 1'b0;
  endtask

  initial begin
    #300us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n    = 1'b0;
    key_n    = 2'b11;
    sw_panic = 1'b0;
    busy     = 1'b0;
    step(3);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      chk("reset_outputs",
          int'({open_req, door_sel, panic_on, panic_rise,
                panic_fall, key_state, req_count}), 0);
      step(1);
    end

    // key 0 press with latency probe
    c = cyc;
    key_n = 2'b10;
    rc = rc + 8'd1;
    rq.push_back('{c + 7, 1'b0, rc});
    step(5);
    chk("key0_before_edge6", int'(key_state[0]), 0);
    step(1);
    chk("key0_at_edge6", int'(key_state[0]), 1);
    step(10);
    key_n = 2'b11;
    step(10);

    // 3-cycle glitch on key 1
    key_n = 2'b01;
    step(3);
    key_n = 2'b11;
    for (int i = 0; i < 12; i++) begin
      chk("glitch_key_state", int'(key_state), 0);
      step(1);
    end
    chk("glitch_req_count", int'(req_count), 1);

    do_press(2'b00, 1'b0, 1'b1, 1'b0);
    do_press(2'b01, 1'b1, 1'b0, 1'b0);
    chk("busy_door_sel", int'(door_sel), 0);
    chk("busy_req_count", int'(req_count), 2);
    do_press(2'b01, 1'b0, 1'b1, 1'b1);

    // panic
    c = cyc;
    sw_panic = 1'b1;
    pq.push_back('{c + 7, 1'b1});
    step(5);
    chk("panic_before_edge6", int'(panic_on), 0);
    step(1);
    chk("panic_at_edge6", int'(panic_on), 1);
    step(5);
    do_press(2'b10, 1'b0, 1'b0, 1'b0);
    chk("panic_door_sel", int'(door_sel), 1);
    chk("panic_req_count", int'(req_count), 3);
    pq.push_back('{cyc + 7, 1'b0});
    sw_panic = 1'b0;
    step(12);
    chk("panic_off", int'(panic_on), 0);

    // wrap of req_count
    for (int i = 0; i < 253; i++)
      do_press(2'b10, 1'b0, 1'b1, 1'b0);
    chk("wrap_req_count", int'(req_count), 0);
    do_press(2'b10, 1'b0, 1'b1, 1'b0);
    do_press(2'b10, 1'b0, 1'b1, 1'b0);
    chk("pre_reset_count", int'(req_count), 2);

    // reset mid-debounce with key 1 held through release
    key_n = 2'b01;
    step(3);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_req_count", int'(req_count), 0);
    chk("reset_key_state", int'(key_state), 0);
    step(3);
    rc = 8'd1;
    rq.push_back('{cyc + 7, 1'b1, rc});
    rst_n = 1'b1;
    step(30);
    key_n = 2'b11;
    step(10);
    chk("final_req_count", int'(req_count), 1);
    chk("req_queue_empty", rq.size(), 0);
    chk("panic_queue_empty", pq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
